nand_flash_target: RTL and testbench

- Synthesizable responder for the NAND flash bus: it plays the flash-chip end of the interface that our flash controller drives with CE/CLE/ALE/WE/RE/WP.
- Used for FPGA emulation and as the bench target for the controller.
- Holds a small page array and one page register, and responds to the ONFI-style command subset read, program, erase, status, ID and reset.
- Drives R/B# busy for a fixed number of cycles while it moves data.

---
 rtl/nand_target_pkg.sv | 46 ++++
 rtl/nand_page_ram.sv | 35 +++
 rtl/nand_flash_target.sv | 256 +++++++++++++++++++++++++
 tb/tb_nand_flash_target.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nand_target_pkg.sv
//------------------------------------------------------------------------------
// Module : nand_target_pkg
// Brief  : Opcodes, FSM states and status-bit positions for the NAND target.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package nand_target_pkg;

    localparam logic [7:0] CMD_READ       = 8'h00;
    localparam logic [7:0] CMD_READ_CONF  = 8'h30;
    localparam logic [7:0] CMD_PROG       = 8'h80;
    localparam logic [7:0] CMD_PROG_CONF  = 8'h10;
    localparam logic [7:0] CMD_ERASE      = 8'h60;
    localparam logic [7:0] CMD_ERASE_CONF = 8'hD0;
    localparam logic [7:0] CMD_STATUS     = 8'h70;
    localparam logic [7:0] CMD_ID         = 8'h90;
    localparam logic [7:0] CMD_RESET      = 8'hFF;

    localparam int STAT_WP   = 7;
    localparam int STAT_RDY  = 6;
    localparam int STAT_FAIL = 0;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_ADDR  = 4'd1,
        S_BUSY_RD  = 4'd2,
        S_DATA_OUT = 4'd3,
        S_PG_ADDR  = 4'd4,
        S_DATA_IN  = 4'd5,
        S_BUSY_PG  = 4'd6,
        S_ER_ADDR  = 4'd7,
        S_BUSY_ER  = 4'd8,
        S_ST_OUT   = 4'd9,
        S_ID_OUT   = 4'd10,
        S_BUSY_RST = 4'd11
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == S_BUSY_RD) || (s == S_BUSY_PG) ||
               (s == S_BUSY_ER) || (s == S_BUSY_RST);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nand_page_ram.sv
//------------------------------------------------------------------------------
// Module : nand_page_ram
// Brief  : Single-port byte RAM holding the flash array, one-cycle read latency.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module nand_page_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);

    localparam int DEPTH = 1 << AW;

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_dout;

    // Flash content survives reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        r_dout <= r_mem[addr];
    end

    assign dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/nand_flash_target.sv
//------------------------------------------------------------------------------
// Module : nand_flash_target
// Brief  : Flash-chip end of the NAND bus: page array, page register, ONFI subset.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module nand_flash_target
    import nand_target_pkg::*;
#(
    parameter int          PAGE_BYTES  = 16,
    parameter int          NUM_PAGES   = 16,
    parameter int          BUSY_CYCLES = 32,
    parameter int          RST_CYCLES  = 8,
    parameter logic [39:0] ID_BYTES    = 40'hEC_D3_51_95_58
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iCE_N,
    input  logic       iCLE,
    input  logic       iALE,
    input  logic       iWE_N,
    input  logic       iRE_N,
    input  logic       iWP_N,
    output logic       oRB_N,
    input  logic [7:0] dq_in,
    output logic [7:0] dq_out,
    output logic       dq_oe
);

    localparam int CW      = $clog2(PAGE_BYTES);
    localparam int RW      = $clog2(NUM_PAGES);
    localparam int CNT_MAX = (BUSY_CYCLES > RST_CYCLES) ? BUSY_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            r_state;
    logic              r_we_d;
    logic              r_re_d;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [1:0]        r_addr_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fail;
    logic              r_stat_en;
    logic [2:0]        r_id_idx;
    logic              r_rb_n;
    logic [7:0]        r_dq_out;
    logic [7:0]        r_page [PAGE_BYTES];
    logic              r_rd_vld;
    logic [CW-1:0]     r_rd_idx;

    logic              w_we_rise;
    logic              w_re_fall;
    logic              w_cmd;
    logic              w_addr;
    logic              w_data;
    logic              w_busy;
    logic              w_busy_last;
    logic              w_out_state;
    logic              w_copy;
    logic [CW-1:0]     w_idx;
    logic [7:0]        w_status;
    logic [CW+RW-1:0]  w_ram_addr;
    logic              w_ram_we;
    logic [7:0]        w_ram_din;
    logic [7:0]        w_ram_dout;

    assign w_we_rise = !iCE_N && !r_we_d && iWE_N;
    assign w_re_fall = !iCE_N && r_re_d && !iRE_N;
    assign w_cmd     = w_we_rise && iCLE && !iALE;
    assign w_addr    = w_we_rise && iALE && !iCLE;
    assign w_data    = w_we_rise && !iCLE && !iALE;

    assign w_busy      = is_busy(r_state);
    assign w_busy_last = (r_state == S_BUSY_RST) ? (r_cnt == CNT_W'(RST_CYCLES - 1))
                                                 : (r_cnt == CNT_W'(BUSY_CYCLES - 1));
    assign w_out_state = (r_state == S_DATA_OUT) || (r_state == S_ST_OUT) ||
                         (r_state == S_ID_OUT) || (w_busy && r_stat_en);

    always_comb begin
        w_status            = '0;
        w_status[STAT_WP]   = iWP_N;
        w_status[STAT_RDY]  = r_rb_n;
        w_status[STAT_FAIL] = r_fail;
    end

    // The busy counter doubles as the byte index for the array copy.
    assign w_copy     = (r_cnt < CNT_W'(PAGE_BYTES));
    assign w_idx      = r_cnt[CW-1:0];
    assign w_ram_addr = {r_row, w_idx};
    assign w_ram_we   = ((r_state == S_BUSY_PG) || (r_state == S_BUSY_ER)) && !r_fail && w_copy;
    assign w_ram_din  = (r_state == S_BUSY_ER) ? 8'hFF : r_page[w_idx];

    nand_page_ram #(
        .AW (CW + RW)
    ) u_ram (
        .clk  (clk),
        .addr (w_ram_addr),
        .we   (w_ram_we),
        .din  (w_ram_din),
        .dout (w_ram_dout)
    );

    assign oRB_N  = r_rb_n;
    assign dq_out = r_dq_out;
    assign dq_oe  = w_out_state && !iCE_N;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_we_d     <= 1'b1;
            r_re_d     <= 1'b1;
            r_col      <= '0;
            r_row      <= '0;
            r_addr_cnt <= '0;
            r_cnt      <= '0;
            r_fail     <= 1'b0;
            r_stat_en  <= 1'b0;
            r_id_idx   <= '0;
            r_rb_n     <= 1'b1;
            r_dq_out   <= 8'hAA;
            r_rd_vld   <= 1'b0;
            r_rd_idx   <= '0;
            for (int i = 0; i < PAGE_BYTES; i++) begin
                r_page[i] <= 8'hFF;
            end
        end else begin
            r_we_d <= iWE_N;
            r_re_d <= iRE_N;

            // Array read data arrives one cycle after its address.
            r_rd_vld <= (r_state == S_BUSY_RD) && w_copy;
            r_rd_idx <= w_idx;
            if (r_rd_vld) begin
                r_page[r_rd_idx] <= w_ram_dout;
            end

            if (w_busy) begin
                if (w_busy_last) begin
                    r_rb_n    <= 1'b1;
                    r_cnt     <= '0;
                    r_stat_en <= 1'b0;
                    if (r_state == S_BUSY_RD) begin
                        r_state <= S_DATA_OUT;
                    end else begin
                        r_state <= r_stat_en ? S_ST_OUT : S_IDLE;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            if (w_re_fall && w_out_state) begin
                if (r_state == S_DATA_OUT) begin
                    r_dq_out <= r_page[r_col];
                    r_col    <= r_col + 1'b1;
                end else if (r_state == S_ID_OUT) begin
                    r_dq_out <= ID_BYTES[8*(4 - int'(r_id_idx)) +: 8];
                    if (r_id_idx < 3'd4) begin
                        r_id_idx <= r_id_idx + 1'b1;
                    end
                end else begin
                    r_dq_out <= w_status;
                end
            end

            if (w_cmd) begin
                if (w_busy) begin
                    if (dq_in == CMD_STATUS) begin
                        r_stat_en <= 1'b1;
                    end else if (dq_in == CMD_RESET) begin
                        r_state   <= S_BUSY_RST;
                        r_rb_n    <= 1'b0;
                        r_cnt     <= '0;
                        r_fail    <= 1'b0;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_stat_en <= 1'b0;
                    end
                end else if (r_state == S_RD_ADDR && r_addr_cnt == 2'd2 &&
                             dq_in == CMD_READ_CONF) begin
                    r_state   <= S_BUSY_RD;
                    r_rb_n    <= 1'b0;
                    r_cnt     <= '0;
                    r_stat_en <= 1'b0;
                end else if ((r_state == S_DATA_IN && dq_in == CMD_PROG_CONF) ||
                             (r_state == S_ER_ADDR && r_addr_cnt == 2'd1 &&
                              dq_in == CMD_ERASE_CONF)) begin
                    r_state   <= (r_state == S_DATA_IN) ? S_BUSY_PG : S_BUSY_ER;
                    r_rb_n    <= 1'b0;
                    r_cnt     <= '0;
                    r_stat_en <= 1'b0;
                    if (!iWP_N) begin
                        r_fail <= 1'b1;
                    end
                end else begin
                    r_addr_cnt <= '0;
                    case (dq_in)
                        CMD_READ: begin
                            r_state <= S_RD_ADDR;
                            r_fail  <= 1'b0;
                        end
                        CMD_PROG: begin
                            r_state <= S_PG_ADDR;
                            r_fail  <= 1'b0;
                            for (int i = 0; i < PAGE_BYTES; i++) begin
                                r_page[i] <= 8'hFF;
                            end
                        end
                        CMD_ERASE: begin
                            r_state <= S_ER_ADDR;
                            r_fail  <= 1'b0;
                        end
                        CMD_STATUS: r_state <= S_ST_OUT;
                        CMD_ID: begin
                            r_state  <= S_ID_OUT;
                            r_id_idx <= '0;
                        end
                        CMD_RESET: begin
                            r_state   <= S_BUSY_RST;
                            r_rb_n    <= 1'b0;
                            r_cnt     <= '0;
                            r_fail    <= 1'b0;
                            r_col     <= '0;
                            r_row     <= '0;
                            r_stat_en <= 1'b0;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end else if (w_addr) begin
                if (r_state == S_RD_ADDR || r_state == S_PG_ADDR) begin
                    if (r_addr_cnt == 2'd0) begin
                        r_col      <= dq_in[CW-1:0];
                        r_addr_cnt <= 2'd1;
                    end else if (r_addr_cnt == 2'd1) begin
                        r_row      <= dq_in[RW-1:0];
                        r_addr_cnt <= 2'd2;
                        if (r_state == S_PG_ADDR) begin
                            r_state <= S_DATA_IN;
                        end
                    end
                end else if (r_state == S_ER_ADDR && r_addr_cnt == 2'd0) begin
                    r_row      <= dq_in[RW-1:0];
                    r_addr_cnt <= 2'd1;
                end
            end else if (w_data && r_state == S_DATA_IN) begin
                r_page[r_col] <= dq_in;
                r_col         <= r_col + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nand_flash_target.sv
//------------------------------------------------------------------------------
// Module : tb_nand_flash_target
// Brief  : Directed self-checking bench for nand_flash_target with read scoreboard.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nand_flash_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce_n, cle, ale, we_n, re_n, wp_n;
    logic       rb_n;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    nand_flash_target dut (
        .clk    (clk),
        .rst    (rst),
        .iCE_N  (ce_n),
        .iCLE   (cle),
        .iALE   (ale),
        .iWE_N  (we_n),
        .iRE_N  (re_n),
        .iWP_N  (wp_n),
        .oRB_N  (rb_n),
        .dq_in  (din),
        .dq_out (dout),
        .dq_oe  (oe)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic c, input logic a, input logic [7:0] b);
        cle  = c;
        ale  = a;
        din  = b;
        we_n = 1'b0;
        tick(1);
        we_n = 1'b1;
        tick(1);
        cle  = 1'b0;
        ale  = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] b);
        bus_write(1'b1, 1'b0, b);
    endtask

    task automatic adr(input logic [7:0] b);
        bus_write(1'b0, 1'b1, b);
    endtask

    task automatic read_pop(input string tag);
        logic [7:0] obs;
        re_n = 1'b0;
        tick(1);
        obs  = dout;
        re_n = 1'b1;
        tick(1);
        if (exp_q.size() == 0) begin
            n_checks++;
            $error("FAIL %s observed=%0h expected=none", tag, obs);
        end else begin
            check(tag, {24'h0, obs}, {24'h0, exp_q.pop_front()});
        end
    endtask

    task automatic wait_busy(input string tag, input int exp_len);
        int n = 0;
        while (rb_n === 1'b0 && n < 2000) begin
            tick(1);
            n++;
        end
        check(tag, n, exp_len);
    endtask

    task automatic prog_page(input logic [7:0] row, input logic [7:0] base, input logic [7:0] step);
        cmd(8'h80);
        adr(8'h00);
        adr(row);
        for (int i = 0; i < 16; i++) begin
            bus_write(1'b0, 1'b0, base + step * 8'(i));
        end
        cmd(8'h10);
    endtask

    task automatic read_start(input logic [7:0] row, input logic [7:0] col);
        cmd(8'h00);
        adr(col);
        adr(row);
        cmd(8'h30);
    endtask

    initial begin
        rst  = 1'b0;
        ce_n = 1'b1;
        cle  = 1'b0;
        ale  = 1'b0;
        we_n = 1'b1;
        re_n = 1'b1;
        wp_n = 1'b1;
        din  = 8'h00;
        tick(3);
        check("rst_rb", {31'h0, rb_n}, 32'd1);
        check("rst_dq", {24'h0, dout}, 32'hAA);
        check("rst_oe", {31'h0, oe}, 32'd0);
        rst = 1'b1;
        tick(2);
        ce_n = 1'b0;

        // Program row 3 with 0..F, then read it back from column 0
        prog_page(8'h03, 8'h00, 8'h01);
        wait_busy("pg_busy", 32);
        read_start(8'h03, 8'h00);
        wait_busy("rd_busy", 32);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 16; i++) read_pop("rd_row3");
        check("rd_oe", {31'h0, oe}, 32'd1);

        // Column start mid-page with wrap; high address bits are dropped
        read_start(8'h13, 8'h1E);
        wait_busy("rd2_busy", 32);
        exp_q.push_back(8'h0E); exp_q.push_back(8'h0F);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        for (int i = 0; i < 4; i++) read_pop("rd_wrap");

        // Write protect: row 5 keeps its earlier content and fail is reported
        prog_page(8'h05, 8'hA0, 8'h01);
        wait_busy("pg5_busy", 32);
        wp_n = 1'b0;
        prog_page(8'h05, 8'h55, 8'h00);
        wait_busy("wp_busy", 32);
        cmd(8'h70);
        exp_q.push_back(8'h41);
        read_pop("wp_status");
        wp_n = 1'b1;
        read_start(8'h05, 8'h00);
        wait_busy("rd5_busy", 32);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 16; i++) read_pop("wp_keep");
        cmd(8'h70);
        exp_q.push_back(8'hC0);
        read_pop("fail_clr");

        // Erase row 3
        cmd(8'h60);
        adr(8'h03);
        cmd(8'hD0);
        wait_busy("er_busy", 32);
        read_start(8'h03, 8'h00);
        wait_busy("rd3e_busy", 32);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'hFF);
        for (int i = 0; i < 16; i++) read_pop("erased");

        // Status while programming row 7; count continues from the 0x10 latch
        prog_page(8'h07, 8'h30, 8'h03);
        tick(5);
        cmd(8'h70);
        exp_q.push_back(8'h80);
        read_pop("st_busy");
        check("st_rb_low", {31'h0, rb_n}, 32'd0);
        wait_busy("st_busy_rem", 23);
        cmd(8'h70);
        exp_q.push_back(8'hC0);
        read_pop("st_ready");
        read_start(8'h07, 8'h00);
        wait_busy("rd7_busy", 32);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h30 + 8'(3 * i));
        for (int i = 0; i < 16; i++) read_pop("rd_row7");

        // ID bytes, last one held
        cmd(8'h90);
        exp_q.push_back(8'hEC); exp_q.push_back(8'hD3); exp_q.push_back(8'h51);
        exp_q.push_back(8'h95); exp_q.push_back(8'h58); exp_q.push_back(8'h58);
        for (int i = 0; i < 6; i++) read_pop("id");

        // Reset aborts a read in progress
        read_start(8'h05, 8'h00);
        tick(5);
        cmd(8'hFF);
        wait_busy("abort_busy", 8);
        cmd(8'h70);
        exp_q.push_back(8'hC0);
        read_pop("abort_status");

        // Deselected chip ignores a command strobe
        ce_n = 1'b1;
        tick(1);
        check("ce_oe", {31'h0, oe}, 32'd0);
        cmd(8'h90);
        ce_n = 1'b0;
        tick(1);
        exp_q.push_back(8'hC0);
        read_pop("ce_ignore");

        check("sb_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
